// File: rtl/tick_div_pkg.sv
// Shared types and default widths for the tick divider.
package tick_div_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } tick_div_state_e;

    localparam int unsigned TICK_DIV_W = 32;
    localparam int unsigned TICK_CNT_W = 16;

endpackage

// File: rtl/tick_divider.sv
// Periodic strobe generator: latches a divisor on enable and pulses tick_o every
// divisor cycles, keeping a wrapping tick count and sticky wrap/zero-divisor flags.
module tick_divider
    import tick_div_pkg::*;
#(
    parameter int unsigned DIV_W = TICK_DIV_W,
    parameter int unsigned CNT_W = TICK_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] divisor_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] tick_cnt_o,
    output logic             wrap_o,
    output logic             err_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    tick_div_state_e r_state;
    tick_div_state_e w_state_next;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_tick;
    logic             r_wrap;
    logic             r_err;

    logic w_load;
    logic w_zero_err;
    logic w_stop;
    logic w_tick_evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_zero_err   = 1'b0;
        w_stop       = 1'b0;
        w_tick_evt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    if (divisor_i != '0) begin
                        w_load       = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_zero_err = 1'b1;
                    end
                end
            end
            RUN: begin
                // Disable wins over a pending tick: nothing issues on the stopping edge.
                if (!enable_i) begin
                    w_stop       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_cnt == '0) begin
                    w_tick_evt = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div      <= '0;
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tick <= w_tick_evt;

            if (w_load) begin
                r_div <= divisor_i;
                r_cnt <= divisor_i - ONE;
            end else if (w_stop) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                // r_div is never zero while in RUN, so the reload cannot underflow.
                r_cnt <= w_tick_evt ? (r_div - ONE) : (r_cnt - ONE);
            end

            if (w_zero_err) begin
                r_err <= 1'b1;
            end else if (w_load) begin
                r_err <= 1'b0;
            end

            if (clear_i) begin
                r_tick_cnt <= '0;
                r_wrap     <= 1'b0;
            end else if (w_tick_evt) begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
                if (r_tick_cnt == '1) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

    assign tick_o     = r_tick;
    assign busy_o     = (r_state == RUN);
    assign tick_cnt_o = r_tick_cnt;
    assign wrap_o     = r_wrap;
    assign err_o      = r_err;

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider with a narrow tick counter so wrap is reachable.
module tb_tick_divider;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [DIV_W-1:0] divisor;
    logic             enable;
    logic             clear;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;
    logic             wrap;
    logic             err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    tick_divider #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .divisor_i (divisor),
        .enable_i  (enable),
        .clear_i   (clear),
        .tick_o    (tick),
        .busy_o    (busy),
        .tick_cnt_o(tick_cnt),
        .wrap_o    (wrap),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tick"}, 32'(tick), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cnt"},  32'(tick_cnt), 0);
        check({tag, "_wrap"}, 32'(wrap), 0);
        check({tag, "_err"},  32'(err), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        divisor = '0;
        enable  = 1'b0;
        clear   = 1'b0;
        step();
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // D = 4: ticks after edges 4, 8, 12
        divisor = 32'd4;
        enable  = 1'b1;
        step();
        check("d4_busy_e0", 32'(busy), 1);
        check("d4_tick_e0", 32'(tick), 0);
        for (int e = 1; e <= 12; e++) begin
            step();
            check($sformatf("d4_tick_e%0d", e), 32'(tick), (e % 4 == 0) ? 1 : 0);
            check($sformatf("d4_busy_e%0d", e), 32'(busy), 1);
        end
        check("d4_cnt_e12", 32'(tick_cnt), 3);

        enable = 1'b0;
        step();
        check("d4_off_busy", 32'(busy), 0);
        check("d4_off_tick", 32'(tick), 0);
        check("d4_off_cnt", 32'(tick_cnt), 3);

        // Zero divisor is rejected, then a legal divisor recovers
        divisor = '0;
        enable  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            check("z_err", 32'(err), 1);
            check("z_busy", 32'(busy), 0);
            check("z_tick", 32'(tick), 0);
        end
        divisor = 32'd4;
        step();
        check("z_rec_err", 32'(err), 0);
        check("z_rec_busy", 32'(busy), 1);
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("z_rec_tick_e%0d", e), 32'(tick), (e == 4) ? 1 : 0);
        end
        check("z_rec_cnt", 32'(tick_cnt), 4);
        enable = 1'b0;
        step();
        check("z_off_busy", 32'(busy), 0);

        // Disable mid-period with a divisor change, then re-enable at D = 2
        divisor = 32'd4;
        enable  = 1'b1;
        step();
        check("dc_busy_e0", 32'(busy), 1);
        step();
        divisor = 32'd2;
        step();
        check("dc_tick_e2", 32'(tick), 0);
        enable = 1'b0;
        step();
        check("dc_busy_e3", 32'(busy), 0);
        check("dc_tick_e3", 32'(tick), 0);
        step();
        check("dc_tick_e4", 32'(tick), 0);
        check("dc_cnt_kept", 32'(tick_cnt), 4);
        enable = 1'b1;
        step();
        check("dc_busy_re0", 32'(busy), 1);
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("dc_tick_re%0d", e), 32'(tick), (e % 2 == 0) ? 1 : 0);
        end
        check("dc_cnt_re6", 32'(tick_cnt), 7);
        enable = 1'b0;
        step();

        // Wrap with D = 1, then clear on a tick cycle
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("wr_clr_cnt", 32'(tick_cnt), 0);
        check("wr_clr_wrap", 32'(wrap), 0);
        divisor = 32'd1;
        enable  = 1'b1;
        step();
        check("wr_busy_e0", 32'(busy), 1);
        check("wr_tick_e0", 32'(tick), 0);
        for (int e = 1; e <= 16; e++) begin
            step();
            check($sformatf("wr_tick_e%0d", e), 32'(tick), 1);
            check($sformatf("wr_cnt_e%0d", e), 32'(tick_cnt), e % 16);
            check($sformatf("wr_wrap_e%0d", e), 32'(wrap), (e == 16) ? 1 : 0);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("wr_cl_tick", 32'(tick), 1);
        check("wr_cl_cnt", 32'(tick_cnt), 0);
        check("wr_cl_wrap", 32'(wrap), 0);
        step();
        check("wr_after_cnt", 32'(tick_cnt), 1);

        // Set err, then async reset between edges while running
        enable = 1'b0;
        step();
        divisor = '0;
        enable  = 1'b1;
        step();
        check("rs_pre_err", 32'(err), 1);
        divisor = 32'd3;
        step();
        check("rs_pre_busy", 32'(busy), 1);
        step();
        step();
        check("rs_pre_cnt", 32'(tick_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rs_async");
        enable = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            check("rs_idle_busy", 32'(busy), 0);
            check("rs_idle_tick", 32'(tick), 0);
        end
        enable = 1'b1;
        step();
        check("rs_en_busy", 32'(busy), 1);
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("rs_tick_e%0d", e), 32'(tick), (e == 3) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
